instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  - ID stage of the MIPS-DLX pipeline. It consumes instruc/PC_plus_1 from instruction_fetch.
//  - Holds the IF/ID latch, a 32x32 register file, the control decoder, load-use hazard detection and J-type redirect.
//  - Drives PC_write/PC_sel/jump_address back to fetch. Drives a registered ID/EX bundle to execute.
// PARAMETERS
//  - PC_W    10  PC / instruction-memory address width
//  - DATA_W  32  datapath and register width
// PORTS
//  - clock          in   1       rising-edge clock
//  - reset_n        in   1       synchronous, active-low reset
//  - instruc        in   32      instruction from fetch memory
//  - PC_plus_1      in   PC_W    fetch PC+1
//  - wb_we          in   1       write-back enable
//  - wb_rd          in   5       write-back destination register
//  - wb_data        in   DATA_W  write-back data
//  - PC_write       out  1       0 = freeze fetch PC (stall)
//  - PC_sel         out  1       1 = fetch takes jump_address
//  - jump_address   out  PC_W    jump target = IF/ID instr[PC_W-1:0]
//  - ex_rs_data     out  DATA_W  registered read A
//  - ex_rt_data     out  DATA_W  registered read B
//  - ex_imm         out  DATA_W  registered sign-extended instr[15:0]
//  - ex_rs/ex_rt/ex_rd  out  5   registered register indices
//  - ex_pc_plus_1   out  PC_W    registered PC+1
//  - ex_ctrl        out  8       {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,branch,illegal}
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): IF/ID instr=0 (NOP) and pc=0. All ID/EX outputs=0. All 32 registers=0.
//    Combinational outputs then settle to PC_write=1, PC_sel=0.
//  - IF/ID update priority per edge: reset > flush > stall (hold) > capture {instruc, PC_plus_1}.
//  - Decode is combinational from IF/ID. ID/EX registers on the next edge. Latency is 1 clock from IF/ID to ex_*.
//  - Opcodes:
//    - R 000000: reg_write, reg_dst
//    - LW 100011: reg_write, mem_read, mem_to_reg, alu_src
//    - SW 101011: mem_write, alu_src
//    - ADDI 001000: reg_write, alu_src
//    - BEQ 000100: branch (resolved in EX)
//    - J 000010: no ex controls
//    - any other opcode: illegal=1, all other ctrl=0
//    - instr==0 decodes as an R-type with rd=0, i.e. a harmless NOP.
//  - Load-use stall: stall=ex_ctrl.mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
//    - On stall: PC_write=0, IF/ID holds, ex_ctrl=0 (bubble). Data fields are don't-care.
//    - Stall lasts exactly 1 cycle, because the bubble clears mem_read.
//  - Jump: id opcode==J && !stall -> PC_sel=1 and jump_address=instr[PC_W-1:0] (combinational).
//    IF/ID is flushed to NOP at that edge. The J itself enters ID/EX with ctrl=0.
//    Stall takes precedence: PC_sel=0 while stalled, and the jump is taken in the cycle after.
//  - Register file: 2 async read ports (rs, rt) and 1 sync write port. Write happens when wb_we && wb_rd!=0.
//    - r0 always reads 0. Writes to r0 are ignored.
//  - Sign extension: ex_imm = {{16{instr[15]}}, instr[15:0]}. PC arithmetic wraps modulo 2^PC_W (done in fetch).
//  - Reset mid-stall or mid-jump clears everything. No pending redirect survives reset.
// CONFIGURATION
//  - WB_BYPASS_EN defined: a read of a register being written the same cycle (wb_we, wb_rd==rs/rt, !=0) returns wb_data.
//  - Not defined: the read returns the old value. The new value is visible from the next cycle.
// STRUCTURE
//  - Shared package dlx_pkg: opcode localparams (OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J), ctrl bit indices, NOP=32'h0.
//  - Sub-module register_file (32 x DATA_W, 2R/1W, honours WB_BYPASS_EN). All other logic stays in instruction_decode.
// TESTING
//  - Reset: hold reset_n=0 for 2 clocks -> all ex_* = 0, PC_write=1, PC_sel=0, reading r1..r31 gives 0.
//  - Write/read: wb r5=32'hDEADBEEF, then ADDI rs=5 imm=16'hFFFF -> ex_rs_data=DEADBEEF, ex_imm=FFFFFFFF, ctrl=alu_src|reg_write.
//  - r0: wb_we, wb_rd=0, data=7 -> reading r0 still gives 0.
//  - Load-use: LW r3,0(r1) followed by ADD r4,r3,r2 -> 1 cycle with PC_write=0 and a zero-ctrl bubble, then ADD issues. ADD r4,r2,r2 gives no stall.
//  - Jump: J target 10'h2A5 -> PC_sel=1, jump_address=2A5 for 1 cycle, next IF/ID=NOP. J directly behind a load-use stall redirects one cycle later.
//  - Bypass: same-cycle write r7=5 while reading r7 -> ex_rs_data=5 with WB_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/dlx_pkg.sv
// dlx_pkg: opcodes, ID/EX control bit positions and the control decoder shared by the ID stage.
package dlx_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_DST    = 2;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_ILLEGAL    = 0;
    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [7:0] decode_ctrl(input logic [5:0] op);
        logic [7:0] c;
        c = '0;
        case (op)
            OP_R:    begin c[CTRL_REG_WRITE] = 1'b1; c[CTRL_REG_DST] = 1'b1; end
            OP_LW:   begin c[CTRL_REG_WRITE] = 1'b1; c[CTRL_MEM_READ] = 1'b1;
                           c[CTRL_MEM_TO_REG] = 1'b1; c[CTRL_ALU_SRC] = 1'b1; end
            OP_SW:   begin c[CTRL_MEM_WRITE] = 1'b1; c[CTRL_ALU_SRC] = 1'b1; end
            OP_ADDI: begin c[CTRL_REG_WRITE] = 1'b1; c[CTRL_ALU_SRC] = 1'b1; end
            OP_BEQ:  c[CTRL_BRANCH] = 1'b1;
            OP_J:    c = '0;
            default: c[CTRL_ILLEGAL] = 1'b1;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/instruction_decode_if.sv
// instruction_decode_if: fetch/write-back inputs and fetch-control / ID-EX outputs of the ID stage.
interface instruction_decode_if #(parameter int PC_W = 10, parameter int DATA_W = 32);
    logic [31:0]       instruc;
    logic [PC_W-1:0]   PC_plus_1;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              PC_write;
    logic              PC_sel;
    logic [PC_W-1:0]   jump_address;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [PC_W-1:0]   ex_pc_plus_1;
    logic [7:0]        ex_ctrl;

    modport master (
        output instruc, PC_plus_1, wb_we, wb_rd, wb_data,
        input  PC_write, PC_sel, jump_address, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_pc_plus_1, ex_ctrl
    );
    modport slave (
        input  instruc, PC_plus_1, wb_we, wb_rd, wb_data,
        output PC_write, PC_sel, jump_address, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_pc_plus_1, ex_ctrl
    );
endinterface

// File: rtl/register_file.sv
// register_file: 32 x DATA_W, two async reads, one sync write, r0 hardwired to zero.
// Optional macro WB_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file #(parameter int DATA_W = 32) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [4:0]        i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [4:0]        i_ra1,
    input  logic [4:0]        i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);
    logic [DATA_W-1:0] r_mem [32];

    always_ff @(posedge clock) begin
        if (!reset_n)
            for (int i = 0; i < 32; i++) r_mem[i] <= '0;
        else if (i_we && i_wa != 5'd0)
            r_mem[i_wa] <= i_wd;
    end

`ifdef WB_BYPASS_EN
    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : (i_we && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : (i_we && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
`else
    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];
`endif
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: DLX ID stage -- IF/ID latch, register file, control decode,
// load-use stall and J redirect, registered ID/EX bundle. Honours WB_BYPASS_EN via register_file.
module instruction_decode
    import dlx_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int DATA_W = 32
) (
    input logic clock,
    input logic reset_n,
    instruction_decode_if.slave bus
);
    logic [31:0]       r_if_instr;
    logic [PC_W-1:0]   r_if_pc;
    logic [DATA_W-1:0] r_ex_rs_data, r_ex_rt_data, r_ex_imm;
    logic [4:0]        r_ex_rs, r_ex_rt, r_ex_rd;
    logic [PC_W-1:0]   r_ex_pc;
    logic [7:0]        r_ex_ctrl;
    logic [5:0]        w_op;
    logic [4:0]        w_rs, w_rt, w_rd;
    logic [DATA_W-1:0] w_rs_data, w_rt_data, w_imm;
    logic              w_stall, w_jump;

    assign w_op  = r_if_instr[31:26];
    assign w_rs  = r_if_instr[25:21];
    assign w_rt  = r_if_instr[20:16];
    assign w_rd  = r_if_instr[15:11];
    assign w_imm = {{(DATA_W-16){r_if_instr[15]}}, r_if_instr[15:0]};
    // The bubble clears mem_read, so a stall can never last more than one cycle.
    assign w_stall = r_ex_ctrl[CTRL_MEM_READ] && r_ex_rt != 5'd0 && (r_ex_rt == w_rs || r_ex_rt == w_rt);
    assign w_jump  = w_op == OP_J && !w_stall;

    register_file #(.DATA_W(DATA_W)) u_rf (
        .clock   (clock),
        .reset_n (reset_n),
        .i_we    (bus.wb_we),
        .i_wa    (bus.wb_rd),
        .i_wd    (bus.wb_data),
        .i_ra1   (w_rs),
        .i_ra2   (w_rt),
        .o_rd1   (w_rs_data),
        .o_rd2   (w_rt_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_if_instr   <= NOP;
            r_if_pc      <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_ex_pc      <= '0;
            r_ex_ctrl    <= '0;
        end else begin
            if (w_jump) begin
                r_if_instr <= NOP;
                r_if_pc    <= '0;
            end else if (!w_stall) begin
                r_if_instr <= bus.instruc;
                r_if_pc    <= bus.PC_plus_1;
            end
            r_ex_rs_data <= w_rs_data;
            r_ex_rt_data <= w_rt_data;
            r_ex_imm     <= w_imm;
            r_ex_rs      <= w_rs;
            r_ex_rt      <= w_rt;
            r_ex_rd      <= w_rd;
            r_ex_pc      <= r_if_pc;
            r_ex_ctrl    <= w_stall ? 8'h00 : decode_ctrl(w_op);
        end
    end

    assign bus.PC_write     = !w_stall;
    assign bus.PC_sel       = w_jump;
    assign bus.jump_address = r_if_instr[PC_W-1:0];
    assign bus.ex_rs_data   = r_ex_rs_data;
    assign bus.ex_rt_data   = r_ex_rt_data;
    assign bus.ex_imm       = r_ex_imm;
    assign bus.ex_rs        = r_ex_rs;
    assign bus.ex_rt        = r_ex_rt;
    assign bus.ex_rd        = r_ex_rd;
    assign bus.ex_pc_plus_1 = r_ex_pc;
    assign bus.ex_ctrl      = r_ex_ctrl;
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed scenarios for the DLX ID stage with hand-computed expectations.
module tb_instruction_decode;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [7:0] C_R = 8'h84, C_LW = 8'hD8, C_ADDI = 8'h88;

    instruction_decode_if #(.PC_W(10), .DATA_W(32)) bus ();
    instruction_decode #(.PC_W(10), .DATA_W(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'b000010, tgt};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.ex_ctrl !== 8'h00) begin n_err++; $display("FAIL reset_ctrl got %h want 00", bus.ex_ctrl); end
        n_cmp++; if ({bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm} !== 96'h0) begin n_err++; $display("FAIL reset_data got %h %h %h want 0", bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm); end
        n_cmp++; if ({bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_pc_plus_1} !== 25'h0) begin n_err++; $display("FAIL reset_idx got %h %h %h %h want 0", bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_pc_plus_1); end
        n_cmp++; if ({bus.PC_write, bus.PC_sel} !== 2'b10) begin n_err++; $display("FAIL reset_pc got %b%b want 10", bus.PC_write, bus.PC_sel); end
    endtask

    task automatic test_reset_mid_jump;
        reset_n = 1'b1;
        bus.instruc = enc_j(26'h2A5);
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b1) begin n_err++; $display("FAIL rmj_pre_sel got %b want 1", bus.PC_sel); end
        reset_n = 1'b0;
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b0) begin n_err++; $display("FAIL rmj_sel got %b want 0", bus.PC_sel); end
        reset_n = 1'b1;
        bus.instruc = 32'h0;
    endtask

    task automatic test_regs_clear;
        int bad = 0;
        for (int i = 1; i < 32; i++) begin
            bus.instruc = enc_r(i[4:0], i[4:0], 5'd0);
            tick();
            tick();
            if (bus.ex_rs_data !== 32'h0 || bus.ex_rt_data !== 32'h0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL regs_clear nonzero_regs got %0d want 0", bad); end
    endtask

    task automatic test_write_read;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        tick();
        bus.wb_we = 1'b0;
        bus.instruc = enc_i(6'b001000, 5'd5, 5'd6, 16'hFFFF);
        bus.PC_plus_1 = 10'h011;
        tick();
        tick();
        n_cmp++; if (bus.ex_rs_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rs_data got %h want deadbeef", bus.ex_rs_data); end
        n_cmp++; if (bus.ex_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wr_imm got %h want ffffffff", bus.ex_imm); end
        n_cmp++; if (bus.ex_ctrl !== C_ADDI) begin n_err++; $display("FAIL wr_ctrl got %h want 88", bus.ex_ctrl); end
        n_cmp++; if ({bus.ex_rs, bus.ex_rt, bus.ex_rd} !== {5'd5, 5'd6, 5'd31}) begin n_err++; $display("FAIL wr_idx got %0d %0d %0d want 5 6 31", bus.ex_rs, bus.ex_rt, bus.ex_rd); end
        n_cmp++; if (bus.ex_pc_plus_1 !== 10'h011) begin n_err++; $display("FAIL wr_pc got %h want 011", bus.ex_pc_plus_1); end
        bus.instruc = enc_i(6'b001000, 5'd0, 5'd1, 16'h7F00);
        tick();
        tick();
        n_cmp++; if (bus.ex_imm !== 32'h00007F00) begin n_err++; $display("FAIL wr_imm_pos got %h want 00007f00", bus.ex_imm); end
        bus.instruc = enc_i(6'b111111, 5'd0, 5'd0, 16'h0);
        tick();
        tick();
        n_cmp++; if (bus.ex_ctrl !== 8'h01) begin n_err++; $display("FAIL illegal_ctrl got %h want 01", bus.ex_ctrl); end
        bus.instruc = enc_i(6'b101011, 5'd0, 5'd0, 16'h0);
        tick();
        tick();
        n_cmp++; if (bus.ex_ctrl !== 8'h28) begin n_err++; $display("FAIL sw_ctrl got %h want 28", bus.ex_ctrl); end
        bus.instruc = enc_i(6'b000100, 5'd0, 5'd0, 16'h0);
        tick();
        tick();
        n_cmp++; if (bus.ex_ctrl !== 8'h02) begin n_err++; $display("FAIL beq_ctrl got %h want 02", bus.ex_ctrl); end
    endtask

    task automatic test_r0;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h7;
        tick();
        bus.wb_we = 1'b0;
        bus.instruc = enc_r(5'd0, 5'd0, 5'd1);
        tick();
        tick();
        n_cmp++; if (bus.ex_rs_data !== 32'h0 || bus.ex_rt_data !== 32'h0) begin n_err++; $display("FAIL r0_read got %h %h want 0", bus.ex_rs_data, bus.ex_rt_data); end
    endtask

    task automatic test_load_use;
        bus.instruc = enc_i(6'b100011, 5'd1, 5'd3, 16'h0);
        tick();
        n_cmp++; if (bus.PC_write !== 1'b1) begin n_err++; $display("FAIL lu_pre_pcw got %b want 1", bus.PC_write); end
        bus.instruc = enc_r(5'd3, 5'd2, 5'd4);
        tick();
        n_cmp++; if (bus.PC_write !== 1'b0 || bus.ex_ctrl !== C_LW) begin n_err++; $display("FAIL lu_stall got pcw=%b ctrl=%h want pcw=0 ctrl=d8", bus.PC_write, bus.ex_ctrl); end
        bus.instruc = enc_i(6'b001000, 5'd0, 5'd9, 16'h1);
        tick();
        n_cmp++; if (bus.ex_ctrl !== 8'h00 || bus.PC_write !== 1'b1) begin n_err++; $display("FAIL lu_bubble got ctrl=%h pcw=%b want ctrl=00 pcw=1", bus.ex_ctrl, bus.PC_write); end
        tick();
        n_cmp++; if (bus.ex_ctrl !== C_R || {bus.ex_rs, bus.ex_rt, bus.ex_rd} !== {5'd3, 5'd2, 5'd4}) begin n_err++; $display("FAIL lu_issue got ctrl=%h idx=%0d %0d %0d want 84 3 2 4", bus.ex_ctrl, bus.ex_rs, bus.ex_rt, bus.ex_rd); end
        bus.instruc = enc_i(6'b100011, 5'd1, 5'd3, 16'h0);
        tick();
        bus.instruc = enc_r(5'd2, 5'd2, 5'd4);
        tick();
        n_cmp++; if (bus.PC_write !== 1'b1) begin n_err++; $display("FAIL lu_nostall_pcw got %b want 1", bus.PC_write); end
        tick();
        n_cmp++; if (bus.ex_ctrl !== C_R) begin n_err++; $display("FAIL lu_nostall_ctrl got %h want 84", bus.ex_ctrl); end
    endtask

    task automatic test_jump;
        bus.instruc = enc_j(26'h2A5);
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b1 || bus.jump_address !== 10'h2A5) begin n_err++; $display("FAIL j_redirect got sel=%b addr=%h want 1 2a5", bus.PC_sel, bus.jump_address); end
        bus.instruc = enc_i(6'b001000, 5'd0, 5'd9, 16'h1);
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b0 || bus.ex_ctrl !== 8'h00) begin n_err++; $display("FAIL j_after got sel=%b ctrl=%h want 0 00", bus.PC_sel, bus.ex_ctrl); end
        tick();
        n_cmp++; if (bus.ex_ctrl !== C_R || bus.ex_rd !== 5'd0) begin n_err++; $display("FAIL j_flush_nop got ctrl=%h rd=%0d want 84 0", bus.ex_ctrl, bus.ex_rd); end
    endtask

    task automatic test_jump_after_stall;
        bus.instruc = enc_i(6'b100011, 5'd1, 5'd3, 16'h0);
        tick();
        bus.instruc = enc_j(26'h00302A5);
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b0 || bus.PC_write !== 1'b0) begin n_err++; $display("FAIL js_stall got sel=%b pcw=%b want 0 0", bus.PC_sel, bus.PC_write); end
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b1 || bus.jump_address !== 10'h2A5 || bus.ex_ctrl !== 8'h00) begin n_err++; $display("FAIL js_redirect got sel=%b addr=%h ctrl=%h want 1 2a5 00", bus.PC_sel, bus.jump_address, bus.ex_ctrl); end
        bus.instruc = enc_i(6'b001000, 5'd0, 5'd9, 16'h1);
        tick();
        n_cmp++; if (bus.PC_sel !== 1'b0) begin n_err++; $display("FAIL js_done got sel=%b want 0", bus.PC_sel); end
    endtask

    task automatic test_bypass;
        logic [31:0] exp_rs;
`ifdef WB_BYPASS_EN
        exp_rs = 32'h5;
`else
        exp_rs = 32'h11;
`endif
        bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h11;
        bus.instruc = enc_r(5'd7, 5'd0, 5'd8);
        tick();
        bus.wb_data = 32'h5;
        tick();
        bus.wb_we = 1'b0;
        n_cmp++; if (bus.ex_rs_data !== exp_rs) begin n_err++; $display("FAIL bypass_same got %h want %h", bus.ex_rs_data, exp_rs); end
        tick();
        n_cmp++; if (bus.ex_rs_data !== 32'h5) begin n_err++; $display("FAIL bypass_next got %h want 00000005", bus.ex_rs_data); end
    endtask

    initial begin
        bus.instruc = 32'h0;
        bus.PC_plus_1 = 10'h0;
        bus.wb_we = 1'b0;
        bus.wb_rd = 5'd0;
        bus.wb_data = 32'h0;
        test_reset();
        test_reset_mid_jump();
        test_regs_clear();
        test_write_read();
        test_r0();
        test_load_use();
        test_jump();
        test_jump_after_stall();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
